// File: rtl/mips_io_pkg.sv
// Shared address-map constants for the MIPS data-bus responder.
package mips_io_pkg;
  localparam logic [15:0] IO_BASE_HI  = 16'hFFFF;
  localparam logic [15:0] RAM_BASE_HI = 16'h0000;

  localparam logic [7:0] LED_OFS   = 8'h00;
  localparam logic [7:0] COUNT_OFS = 8'h04;
  localparam logic [7:0] CMP_OFS   = 8'h08;
  localparam logic [7:0] STAT_OFS  = 8'h0C;
  localparam logic [7:0] SW_OFS    = 8'h10;

  localparam int STAT_MATCH_BIT = 0;
  localparam int STAT_EN_BIT    = 1;
endpackage

// File: rtl/mips_dbus_resp_io_timer.sv
// Timer block: prescaler, free-running COUNT, COMPARE and sticky match STATUS.
module io_timer
  import mips_io_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic [31:0] count_wdata,
  input  logic        cmp_we,
  input  logic [31:0] cmp_wdata,
  input  logic        stat_we,
  input  logic [1:0]  stat_wdata,
  output logic [31:0] count_rdata,
  output logic [31:0] cmp_rdata,
  output logic [31:0] stat_rdata,
  output logic        timer_match
);
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps_q, ps_d;
  logic [31:0]     count_q, count_d, count_inc;
  logic [31:0]     cmp_q, cmp_d;
  logic            en_q, en_d;
  logic            match_q, match_d;
  logic            tick, match_set;

  always_comb begin
    tick      = en_q && (ps_q == PS_LAST);
    count_inc = count_q + 32'd1;
    match_set = tick && (count_inc == cmp_q);

    ps_d = ps_q;
    if (en_q) ps_d = tick ? '0 : ps_q + PS_W'(1);

    // A CPU load wins over the tick increment; the prescaler is left alone.
    count_d = count_q;
    if (count_we)  count_d = count_wdata;
    else if (tick) count_d = count_inc;

    cmp_d = cmp_we ? cmp_wdata : cmp_q;
    en_d  = stat_we ? stat_wdata[STAT_EN_BIT] : en_q;

    // Set has priority over write-1-to-clear in the same cycle.
    match_d = match_q;
    if (stat_we && stat_wdata[STAT_MATCH_BIT]) match_d = 1'b0;
    if (match_set) match_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ps_q    <= '0;
      count_q <= '0;
      cmp_q   <= 32'hFFFF_FFFF;
      en_q    <= 1'b0;
      match_q <= 1'b0;
    end else begin
      ps_q    <= ps_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      en_q    <= en_d;
      match_q <= match_d;
    end
  end

  assign count_rdata = count_q;
  assign cmp_rdata   = cmp_q;
  assign stat_rdata  = {30'd0, en_q, match_q};
  assign timer_match = match_q;
endmodule

// File: rtl/mips_dbus_resp.sv
// Memory-side data-bus responder: word RAM plus LED, timer and switch I/O.
module mips_dbus_resp
  import mips_io_pkg::*;
#(
  parameter int RAM_WORDS = 64,
  parameter int PRESCALE  = 1,
  parameter int LED_W     = 8,
  parameter int SW_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memwrite,
  input  logic [31:0]      memaddr,
  input  logic [31:0]      memwritedata,
  output logic [31:0]      memreaddata,
  input  logic [SW_W-1:0]  switches,
  output logic [LED_W-1:0] leds,
  output logic             timer_match
);
  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0]      mem_q [RAM_WORDS];
  logic [LED_W-1:0] leds_q, leds_d;
  logic [SW_W-1:0]  sw_meta_q, sw_sync_q;

  logic          ram_sel, io_sel, ram_we;
  logic [AW-1:0] word_idx;
  logic [7:0]    io_ofs;
  logic          count_we, cmp_we, stat_we;
  logic [31:0]   count_rdata, cmp_rdata, stat_rdata;
  logic          unused_addr;

  assign ram_sel  = (memaddr[31:16] == RAM_BASE_HI);
  assign io_sel   = (memaddr[31:16] == IO_BASE_HI);
  assign word_idx = memaddr[AW+1:2];
  assign io_ofs   = memaddr[7:0];
  assign unused_addr = ^memaddr;

  assign ram_we   = memwrite && ram_sel;
  assign count_we = memwrite && io_sel && (io_ofs == COUNT_OFS);
  assign cmp_we   = memwrite && io_sel && (io_ofs == CMP_OFS);
  assign stat_we  = memwrite && io_sel && (io_ofs == STAT_OFS);

  always_comb begin
    leds_d = leds_q;
    if (memwrite && io_sel && (io_ofs == LED_OFS)) leds_d = memwritedata[LED_W-1:0];
  end

  // RAM has no reset; its contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (ram_we) mem_q[word_idx] <= memwritedata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      leds_q    <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      leds_q    <= leds_d;
      sw_meta_q <= switches;
      sw_sync_q <= sw_meta_q;
    end
  end

  io_timer #(.PRESCALE(PRESCALE)) u_timer (
    .clk         (clk),
    .reset       (reset),
    .count_we    (count_we),
    .count_wdata (memwritedata),
    .cmp_we      (cmp_we),
    .cmp_wdata   (memwritedata),
    .stat_we     (stat_we),
    .stat_wdata  (memwritedata[1:0]),
    .count_rdata (count_rdata),
    .cmp_rdata   (cmp_rdata),
    .stat_rdata  (stat_rdata),
    .timer_match (timer_match)
  );

  always_comb begin
    memreaddata = 32'h0;
    if (ram_sel) begin
      memreaddata = mem_q[word_idx];
    end else if (io_sel) begin
      case (io_ofs)
        LED_OFS:   memreaddata = 32'(leds_q);
        COUNT_OFS: memreaddata = count_rdata;
        CMP_OFS:   memreaddata = cmp_rdata;
        STAT_OFS:  memreaddata = stat_rdata;
        SW_OFS:    memreaddata = 32'(sw_sync_q);
        default:   memreaddata = 32'h0;
      endcase
    end
  end

  assign leds = leds_q;
endmodule

// File: tb/tb_mips_dbus_resp.sv
// Directed bench for mips_dbus_resp: RAM, LED, timer, switch sync and reset.
module tb_mips_dbus_resp;
  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] memaddr;
  logic [31:0] memwritedata;
  logic [31:0] memreaddata;
  logic [7:0]  switches;
  logic [7:0]  leds;
  logic        timer_match;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] A_LED = 32'hFFFF_0000;
  localparam logic [31:0] A_CNT = 32'hFFFF_0004;
  localparam logic [31:0] A_CMP = 32'hFFFF_0008;
  localparam logic [31:0] A_ST  = 32'hFFFF_000C;
  localparam logic [31:0] A_SW  = 32'hFFFF_0010;

  mips_dbus_resp #(.RAM_WORDS(64), .PRESCALE(1), .LED_W(8), .SW_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .memwrite     (memwrite),
    .memaddr      (memaddr),
    .memwritedata (memwritedata),
    .memreaddata  (memreaddata),
    .switches     (switches),
    .leds         (leds),
    .timer_match  (timer_match)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    memwrite = 1'b0;
    memaddr  = addr;
    #1;
    chk(tag, memreaddata, exp);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    memwrite     = 1'b1;
    memaddr      = addr;
    memwritedata = data;
    step();
    memwrite = 1'b0;
  endtask

  initial begin
    reset = 1'b1; memwrite = 1'b0; memaddr = '0; memwritedata = '0; switches = '0;
    step(); step();
    reset = 1'b0;

    // reset state
    rd(A_LED, 32'h0, "rst_led");
    rd(A_CNT, 32'h0, "rst_count");
    rd(A_CMP, 32'hFFFF_FFFF, "rst_cmp");
    rd(A_ST,  32'h0, "rst_status");
    rd(A_SW,  32'h0, "rst_sw");
    rd(32'hFFFF_0014, 32'h0, "undef_ofs");
    chk("rst_match", 32'(timer_match), 32'h0);
    chk("rst_leds", 32'(leds), 32'h0);

    wr(A_LED, 32'h0000_00A5);
    chk("leds_a5", 32'(leds), 32'hA5);
    rd(A_LED, 32'hA5, "led_readback");

    // RAM, aliasing, unmapped
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_rd");
    rd(32'h0000_0110, 32'hDEAD_BEEF, "ram_alias");
    rd(32'h1234_0000, 32'h0, "unmapped_rd");
    wr(32'h1234_0010, 32'h1111_1111);
    rd(32'h0000_0010, 32'hDEAD_BEEF, "unmapped_wr_ignored");
    wr(A_SW, 32'hFFFF_FFFF);
    rd(A_SW, 32'h0, "sw_ro");

    // timer counting and match
    wr(A_CMP, 32'd5);
    wr(A_ST, 32'd2);
    rd(A_CNT, 32'd0, "cnt0");
    for (int i = 1; i <= 5; i++) begin
      step();
      rd(A_CNT, 32'(i), $sformatf("cnt%0d", i));
      chk($sformatf("match_at%0d", i), 32'(timer_match), (i == 5) ? 32'h1 : 32'h0);
    end
    step();
    rd(A_CNT, 32'd6, "cnt6");
    chk("match_sticky", 32'(timer_match), 32'h1);
    wr(A_ST, 32'd3);
    rd(A_CNT, 32'd7, "cnt7");
    chk("match_w1c", 32'(timer_match), 32'h0);
    rd(A_ST, 32'd2, "status_en");
    step();
    rd(A_CNT, 32'd8, "cnt8");

    // wrap and write override
    wr(A_CNT, 32'hFFFF_FFFE);
    rd(A_CNT, 32'hFFFF_FFFE, "cnt_load");
    step();
    rd(A_CNT, 32'hFFFF_FFFF, "cnt_max");
    step();
    rd(A_CNT, 32'h0, "cnt_wrap");
    wr(A_CNT, 32'd100);
    rd(A_CNT, 32'd100, "cnt_override");
    step();
    rd(A_CNT, 32'd101, "cnt101");

    // set vs W1C in the same cycle
    wr(A_CMP, 32'd104);
    step();
    rd(A_CNT, 32'd103, "cnt103");
    wr(A_ST, 32'd3);
    rd(A_CNT, 32'd104, "cnt104");
    chk("set_beats_clr", 32'(timer_match), 32'h1);
    rd(A_ST, 32'd3, "status_3");
    wr(A_ST, 32'd2);
    chk("w0_keeps_match", 32'(timer_match), 32'h1);
    rd(A_CNT, 32'd105, "cnt105");

    // disable freezes, re-enable resumes
    wr(A_ST, 32'd0);
    rd(A_CNT, 32'd106, "cnt_disable_edge");
    step(); step();
    rd(A_CNT, 32'd106, "cnt_frozen");
    chk("match_held_dis", 32'(timer_match), 32'h1);
    wr(A_ST, 32'd2);
    rd(A_CNT, 32'd106, "cnt_reenable_edge");
    step();
    rd(A_CNT, 32'd107, "cnt_resume");

    // switch synchroniser latency
    switches = 8'h3C;
    rd(A_SW, 32'h0, "sw_lat0");
    step();
    rd(A_SW, 32'h0, "sw_lat1");
    step();
    rd(A_SW, 32'h3C, "sw_lat2");

    // reset mid-operation
    wr(A_CNT, 32'd42);
    rd(A_CNT, 32'd42, "cnt42");
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("post_rst_leds", 32'(leds), 32'h0);
    chk("post_rst_match", 32'(timer_match), 32'h0);
    rd(A_CNT, 32'h0, "post_rst_count");
    rd(A_ST,  32'h0, "post_rst_status");
    rd(A_CMP, 32'hFFFF_FFFF, "post_rst_cmp");
    rd(A_SW,  32'h0, "post_rst_sw");
    rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_survives_rst");
    step();
    rd(A_CNT, 32'h0, "post_rst_disabled");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
